// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the icache/dcache memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 26;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_WB = 3'd2,
    D_RD = 3'd3,
    RESP = 3'd4
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // On a conflict the dcache wins unless it also took the previous grant.
  function automatic owner_t pick_owner(input logic req_i, input logic req_d, input owner_t last);
    if (req_i && req_d) begin
      return (last == OWN_D) ? OWN_I : OWN_D;
    end
    return req_d ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache write-back/fill sequences onto one
// line-wide memory port; one transaction in flight at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_mem,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  output logic [LINE_W-1:0] data_to_I,
  output logic              read_ready_I,
  input  logic              reqD_mem,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic              reqD_cache_write,
  input  logic [ADDR_W-1:0] reqAddrD_write_mem,
  input  logic [LINE_W-1:0] data_to_mem,
  output logic [LINE_W-1:0] data_from_mem,
  output logic              read_ready_from_mem,
  output logic              written_data_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              state_q, state_d;
  owner_t              last_q, last_d;
  owner_t              owner_q, owner_d;
  owner_t              win;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0]   wb_data_q, wb_data_d;
  logic [LINE_W-1:0]   data_i_q, data_i_d;
  logic [LINE_W-1:0]   data_d_q, data_d_d;
  logic                ack_q, ack_d;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    fill_addr_d = fill_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    data_i_d    = data_i_q;
    data_d_d    = data_d_q;
    ack_d       = 1'b0;
    win         = pick_owner(reqI_mem, reqD_mem, last_q);

    case (state_q)
      IDLE: begin
        if (reqI_mem || reqD_mem) begin
          owner_d = win;
          last_d  = win;
          if (win == OWN_D) begin
            fill_addr_d = reqAddrD_mem;
            wb_addr_d   = reqAddrD_write_mem;
            wb_data_d   = data_to_mem;
            state_d     = reqD_cache_write ? D_WB : D_RD;
          end else begin
            fill_addr_d = reqAddrI_mem;
            state_d     = I_RD;
          end
        end
      end
      I_RD: begin
        if (mem_ready) begin
          data_i_d = mem_rdata;
          state_d  = RESP;
        end
      end
      D_WB: begin
        if (mem_ready) begin
          ack_d   = 1'b1;
          state_d = D_RD;
        end
      end
      D_RD: begin
        if (mem_ready) begin
          data_d_d = mem_rdata;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= OWN_I;
      owner_q     <= OWN_I;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      data_i_q    <= '0;
      data_d_q    <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      fill_addr_q <= fill_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      data_i_q    <= data_i_d;
      data_d_q    <= data_d_d;
      ack_q       <= ack_d;
    end
  end

  // Memory-side outputs derive only from state and latched request fields,
  // so they stay stable for the whole transfer and drop at once on reset.
  assign mem_req   = (state_q == I_RD) || (state_q == D_WB) || (state_q == D_RD);
  assign mem_we    = (state_q == D_WB);
  assign mem_addr  = (state_q == D_WB) ? wb_addr_q : fill_addr_q;
  assign mem_wdata = wb_data_q;

  assign read_ready_I        = (state_q == RESP) && (owner_q == OWN_I);
  assign read_ready_from_mem = (state_q == RESP) && (owner_q == OWN_D);
  assign written_data_ack    = ack_q;
  assign data_to_I           = data_i_q;
  assign data_from_mem       = data_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// request streams checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 26;
  localparam int LW = 128;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ACK = 2;
  localparam int K_RI  = 3;
  localparam int K_RDD = 4;

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    int          cyc;
    int          reqc;
  } ev_t;

  typedef struct {
    logic          wb;
    logic [AW-1:0] addr;
    logic [AW-1:0] vaddr;
    logic [LW-1:0] vdata;
  } req_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqI_mem;
  logic [AW-1:0] reqAddrI_mem;
  logic [LW-1:0] data_to_I;
  logic          read_ready_I;
  logic          reqD_mem;
  logic [AW-1:0] reqAddrD_mem;
  logic          reqD_cache_write;
  logic [AW-1:0] reqAddrD_write_mem;
  logic [LW-1:0] data_to_mem;
  logic [LW-1:0] data_from_mem;
  logic          read_ready_from_mem;
  logic          written_data_ack;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;

  logic          rsp_ready;
  logic          spur_ready;
  assign mem_ready = rsp_ready | spur_ready;

  int            tests_run = 0;
  int            fails = 0;
  int            cyc = 0;
  int            lat_fix;
  int            stab_err;
  int            raise_i, raise_d;
  logic [LW-1:0] salt;

  ev_t  op_q[$];
  ev_t  pl_q[$];
  ev_t  exp_ops[$];
  ev_t  exp_pls[$];
  req_t qi_pend[$];
  req_t qd_pend[$];

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .reqI_mem            (reqI_mem),
    .reqAddrI_mem        (reqAddrI_mem),
    .data_to_I           (data_to_I),
    .read_ready_I        (read_ready_I),
    .reqD_mem            (reqD_mem),
    .reqAddrD_mem        (reqAddrD_mem),
    .reqD_cache_write    (reqD_cache_write),
    .reqAddrD_write_mem  (reqAddrD_write_mem),
    .data_to_mem         (data_to_mem),
    .data_from_mem       (data_from_mem),
    .read_ready_from_mem (read_ready_from_mem),
    .written_data_ack    (written_data_ack),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ready           (mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {32'(a) ^ 32'hDEAD_BEEF, 32'(a) * 32'd7 + 32'd3, ~32'(a), 32'(a)} ^ salt;
  endfunction

  // Memory responder: completes each request after lat cycles of mem_req.
  initial begin
    int cnt;
    int cur_lat;
    logic [AW-1:0] a0;
    logic          we0;
    logic [LW-1:0] wd0;
    cnt = 0; cur_lat = 1; rsp_ready = 1'b0; mem_rdata = '0;
    a0 = '0; we0 = 1'b0; wd0 = '0;
    forever begin
      @(negedge clk);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (reset) begin
        cnt = 0;
        rsp_ready = 1'b0;
      end else begin
        if (rsp_ready) cnt = 0;
        rsp_ready = 1'b0;
        if (mem_req) begin
          if (cnt == 0) begin
            a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata;
            cur_lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
          end else if (mem_addr !== a0 || mem_we !== we0 || (we0 && mem_wdata !== wd0)) begin
            stab_err++;
          end
          cnt++;
          if (cnt >= cur_lat) begin
            rsp_ready = 1'b1;
            if (mem_we) begin
              op_q.push_back(ev_t'{K_WR, mem_addr, mem_wdata, cyc, cnt});
            end else begin
              mem_rdata = line_of(mem_addr);
              op_q.push_back(ev_t'{K_RD, mem_addr, '0, cyc, cnt});
            end
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Pulse monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (written_data_ack)    pl_q.push_back(ev_t'{K_ACK, '0, '0, cyc, 0});
      if (read_ready_I)        pl_q.push_back(ev_t'{K_RI, '0, data_to_I, cyc, 0});
      if (read_ready_from_mem) pl_q.push_back(ev_t'{K_RDD, '0, data_from_mem, cyc, 0});
    end
  end

  // Requester agents: hold req until the ready pulse, then present the next queued one.
  initial begin
    req_t r;
    reqI_mem = 1'b0; reqAddrI_mem = '0;
    reqD_mem = 1'b0; reqAddrD_mem = '0; reqD_cache_write = 1'b0;
    reqAddrD_write_mem = '0; data_to_mem = '0;
    raise_i = 0; raise_d = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        reqI_mem = 1'b0;
        reqD_mem = 1'b0;
      end else begin
        if (reqI_mem && read_ready_I) reqI_mem = 1'b0;
        if (!reqI_mem && qi_pend.size() > 0) begin
          r = qi_pend.pop_front();
          reqI_mem = 1'b1; reqAddrI_mem = r.addr; raise_i = cyc;
        end
        if (reqD_mem && read_ready_from_mem) reqD_mem = 1'b0;
        if (!reqD_mem && qd_pend.size() > 0) begin
          r = qd_pend.pop_front();
          reqD_mem = 1'b1; reqAddrD_mem = r.addr; reqD_cache_write = r.wb;
          reqAddrD_write_mem = r.vaddr; data_to_mem = r.vdata; raise_d = cyc;
        end
      end
    end
  end

  // Reference: service order and the memory/pulse traffic each service produces.
  task automatic model_run(input req_t ri[$], input req_t rd[$]);
    bit   last_d = 1'b0;
    bit   take_d;
    req_t r;
    exp_ops.delete();
    exp_pls.delete();
    while (ri.size() > 0 || rd.size() > 0) begin
      if (ri.size() > 0 && rd.size() > 0) take_d = !last_d;
      else take_d = (rd.size() > 0);
      if (take_d) begin
        r = rd.pop_front();
        if (r.wb) begin
          exp_ops.push_back(ev_t'{K_WR, r.vaddr, r.vdata, 0, 0});
          exp_pls.push_back(ev_t'{K_ACK, '0, '0, 0, 0});
        end
        exp_ops.push_back(ev_t'{K_RD, r.addr, '0, 0, 0});
        exp_pls.push_back(ev_t'{K_RDD, '0, line_of(r.addr), 0, 0});
      end else begin
        r = ri.pop_front();
        exp_ops.push_back(ev_t'{K_RD, r.addr, '0, 0, 0});
        exp_pls.push_back(ev_t'{K_RI, '0, line_of(r.addr), 0, 0});
      end
      last_d = take_d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    qi_pend.delete();
    qd_pend.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op_q.delete();
    pl_q.delete();
    stab_err = 0;
  endtask

  task automatic wait_pl(input int n, input int budget);
    for (int k = 0; k < budget && pl_q.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({mem_req, mem_we, read_ready_I, read_ready_from_mem, written_data_ack} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {mem_req, mem_we, read_ready_I, read_ready_from_mem, written_data_ack});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++; $display("FAIL reset_mem_bus: addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    tests_run++;
    if (data_to_I !== '0 || data_from_mem !== '0) begin
      fails++; $display("FAIL reset_data: I %h D %h want 0", data_to_I, data_from_mem);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0) begin
      fails++; $display("FAIL idle_mem_req: got %b want 0", mem_req);
    end
    op_q.delete(); pl_q.delete(); stab_err = 0;
  endtask

  task automatic test_single_i();
    lat_fix = 3;
    @(posedge clk); #1;
    qi_pend.push_back(req_t'{1'b0, 26'h0000040, '0, '0});
    wait_pl(1, 40);
    tests_run++;
    if (op_q.size() != 1 || pl_q.size() != 1) begin
      fails++; $display("FAIL single_counts: ops %0d pulses %0d want 1 1", op_q.size(), pl_q.size());
    end
    if (op_q.size() >= 1) begin
      tests_run++;
      if (op_q[0].kind != K_RD || op_q[0].addr !== 26'h40 || op_q[0].reqc != 3) begin
        fails++;
        $display("FAIL single_op: kind %0d addr %h req_cycles %0d want 1 40 3",
                 op_q[0].kind, op_q[0].addr, op_q[0].reqc);
      end
    end
    if (pl_q.size() >= 1) begin
      tests_run++;
      if (pl_q[0].kind != K_RI || pl_q[0].cyc != raise_i + 4) begin
        fails++;
        $display("FAIL single_pulse: kind %0d cyc %0d want %0d %0d", pl_q[0].kind, pl_q[0].cyc, K_RI, raise_i + 4);
      end
      tests_run++;
      if (pl_q[0].data !== line_of(26'h40)) begin
        fails++; $display("FAIL single_data: got %h want %h", pl_q[0].data, line_of(26'h40));
      end
    end
    tests_run++;
    if (mem_req !== 1'b0 || stab_err != 0) begin
      fails++; $display("FAIL single_idle: mem_req %b stab_err %0d want 0 0", mem_req, stab_err);
    end
  endtask

  task automatic test_writeback();
    logic [LW-1:0] vd;
    vd = {$urandom, $urandom, $urandom, $urandom};
    lat_fix = 2;
    op_q.delete(); pl_q.delete();
    @(posedge clk); #1;
    qd_pend.push_back(req_t'{1'b1, 26'h0000020, 26'h0000010, vd});
    wait_pl(2, 40);
    tests_run++;
    if (op_q.size() != 2 || pl_q.size() != 2) begin
      fails++; $display("FAIL wb_counts: ops %0d pulses %0d want 2 2", op_q.size(), pl_q.size());
    end
    if (op_q.size() >= 2 && pl_q.size() >= 2) begin
      tests_run++;
      if (op_q[0].kind != K_WR || op_q[0].addr !== 26'h10 || op_q[0].data !== vd) begin
        fails++;
        $display("FAIL wb_write: kind %0d addr %h data %h want 0 10 %h", op_q[0].kind, op_q[0].addr, op_q[0].data, vd);
      end
      tests_run++;
      if (pl_q[0].kind != K_ACK || pl_q[0].cyc != op_q[0].cyc + 1) begin
        fails++;
        $display("FAIL wb_ack: kind %0d cyc %0d want %0d %0d", pl_q[0].kind, pl_q[0].cyc, K_ACK, op_q[0].cyc + 1);
      end
      tests_run++;
      if (op_q[1].kind != K_RD || op_q[1].addr !== 26'h20) begin
        fails++; $display("FAIL wb_read: kind %0d addr %h want 1 20", op_q[1].kind, op_q[1].addr);
      end
      tests_run++;
      if (pl_q[1].kind != K_RDD || pl_q[1].data !== line_of(26'h20)) begin
        fails++;
        $display("FAIL wb_fill: kind %0d data %h want %0d %h", pl_q[1].kind, pl_q[1].data, K_RDD, line_of(26'h20));
      end
    end
    tests_run++;
    if (data_to_I !== line_of(26'h40) || stab_err != 0) begin
      fails++; $display("FAIL wb_hold_i: data_to_I %h stab_err %0d want %h 0", data_to_I, stab_err, line_of(26'h40));
    end
  endtask

  task automatic test_conflict();
    do_reset();
    lat_fix = 2;
    @(posedge clk); #1;
    qi_pend.push_back(req_t'{1'b0, 26'h0000100, '0, '0});
    qd_pend.push_back(req_t'{1'b0, 26'h0000200, '0, '0});
    wait_pl(2, 40);
    tests_run++;
    if (pl_q.size() != 2 || op_q.size() != 2) begin
      fails++; $display("FAIL conflict_counts: pulses %0d ops %0d want 2 2", pl_q.size(), op_q.size());
    end else begin
      tests_run++;
      if (pl_q[0].kind != K_RDD || pl_q[1].kind != K_RI) begin
        fails++; $display("FAIL conflict_order: got %0d,%0d want %0d,%0d", pl_q[0].kind, pl_q[1].kind, K_RDD, K_RI);
      end
      tests_run++;
      if (op_q[0].addr !== 26'h200 || op_q[1].addr !== 26'h100) begin
        fails++; $display("FAIL conflict_addr: got %h,%h want 200,100", op_q[0].addr, op_q[1].addr);
      end
    end
  endtask

  task automatic test_alternate();
    int want[4];
    want = '{K_RDD, K_RI, K_RDD, K_RI};
    do_reset();
    lat_fix = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      qi_pend.push_back(req_t'{1'b0, AW'(26'h300 + k), '0, '0});
      qd_pend.push_back(req_t'{1'b0, AW'(26'h400 + k), '0, '0});
    end
    wait_pl(4, 60);
    tests_run++;
    if (pl_q.size() != 4) begin
      fails++; $display("FAIL alt_count: got %0d want 4", pl_q.size());
    end
    for (int k = 0; k < 4 && k < pl_q.size(); k++) begin
      tests_run++;
      if (pl_q[k].kind != want[k]) begin
        fails++; $display("FAIL alt_grant%0d: got %0d want %0d", k, pl_q[k].kind, want[k]);
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    lat_fix = 3;
    spur_ready = 1'b1;
    @(negedge clk);
    spur_ready = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (pl_q.size() != 0 || op_q.size() != 0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL spur_quiet: pulses %0d ops %0d mem_req %b want 0 0 0", pl_q.size(), op_q.size(), mem_req);
    end
    tests_run++;
    if (data_to_I !== '0 || data_from_mem !== '0) begin
      fails++; $display("FAIL spur_data: I %h D %h want 0", data_to_I, data_from_mem);
    end
    @(posedge clk); #1;
    qi_pend.push_back(req_t'{1'b0, 26'h0000055, '0, '0});
    wait_pl(1, 40);
    tests_run++;
    if (pl_q.size() != 1) begin
      fails++; $display("FAIL spur_after_count: got %0d want 1", pl_q.size());
    end else if (pl_q[0].kind != K_RI || pl_q[0].cyc != raise_i + 4 || pl_q[0].data !== line_of(26'h55)) begin
      fails++;
      $display("FAIL spur_after: kind %0d cyc %0d data %h want %0d %0d %h",
               pl_q[0].kind, pl_q[0].cyc, pl_q[0].data, K_RI, raise_i + 4, line_of(26'h55));
    end
  endtask

  task automatic test_reset_mid();
    lat_fix = 6;
    op_q.delete(); pl_q.delete();
    @(posedge clk); #1;
    qd_pend.push_back(req_t'{1'b1, 26'h0000020, 26'h0000010, {4{32'h1234_5678}}});
    @(negedge clk);
    repeat (3) @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 26'h10) begin
      fails++; $display("FAIL mid_in_wb: req %b we %b addr %h want 1 1 10", mem_req, mem_we, mem_addr);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || written_data_ack !== 1'b0) begin
      fails++; $display("FAIL mid_reset_now: req %b we %b ack %b want 0 0 0", mem_req, mem_we, written_data_ack);
    end
    tests_run++;
    if (data_to_I !== '0) begin
      fails++; $display("FAIL mid_reset_data: got %h want 0", data_to_I);
    end
    qd_pend.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (pl_q.size() != 0 || op_q.size() != 0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL mid_abandon: pulses %0d ops %0d mem_req %b want 0 0 0", pl_q.size(), op_q.size(), mem_req);
    end
  endtask

  task automatic test_random();
    req_t ri[$];
    req_t rd[$];
    for (int it = 0; it < 3; it++) begin
      do_reset();
      lat_fix = 0;
      ri.delete(); rd.delete();
      for (int k = 0; k < int'($urandom_range(2, 6)); k++)
        ri.push_back(req_t'{1'b0, AW'($urandom), '0, '0});
      for (int k = 0; k < int'($urandom_range(2, 6)); k++)
        rd.push_back(req_t'{1'($urandom), AW'($urandom), AW'($urandom),
                            {$urandom, $urandom, $urandom, $urandom}});
      model_run(ri, rd);
      @(posedge clk); #1;
      foreach (ri[k]) qi_pend.push_back(ri[k]);
      foreach (rd[k]) qd_pend.push_back(rd[k]);
      wait_pl(exp_pls.size(), 400);
      tests_run++;
      if (pl_q.size() != exp_pls.size() || op_q.size() != exp_ops.size()) begin
        fails++;
        $display("FAIL rand%0d_counts: pulses %0d ops %0d want %0d %0d",
                 it, pl_q.size(), op_q.size(), exp_pls.size(), exp_ops.size());
      end
      for (int k = 0; k < exp_ops.size() && k < op_q.size(); k++) begin
        tests_run++;
        if (op_q[k].kind != exp_ops[k].kind || op_q[k].addr !== exp_ops[k].addr ||
            op_q[k].data !== exp_ops[k].data) begin
          fails++;
          $display("FAIL rand%0d_op%0d: kind %0d addr %h data %h want %0d %h %h", it, k,
                   op_q[k].kind, op_q[k].addr, op_q[k].data,
                   exp_ops[k].kind, exp_ops[k].addr, exp_ops[k].data);
        end
      end
      for (int k = 0; k < exp_pls.size() && k < pl_q.size(); k++) begin
        tests_run++;
        if (pl_q[k].kind != exp_pls[k].kind || pl_q[k].data !== exp_pls[k].data) begin
          fails++;
          $display("FAIL rand%0d_pulse%0d: kind %0d data %h want %0d %h", it, k,
                   pl_q[k].kind, pl_q[k].data, exp_pls[k].kind, exp_pls[k].data);
        end
      end
      tests_run++;
      if (stab_err != 0) begin
        fails++; $display("FAIL rand%0d_stable: got %0d want 0", it, stab_err);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    spur_ready = 1'b0;
    lat_fix = 3;
    stab_err = 0;
    salt = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_single_i();
    test_writeback();
    test_conflict();
    test_alternate();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
